// File: rtl/reg_file_nrw.sv
// General-purpose register file: one byte-strobed write port, two combinational read ports,
// optional hardwired-zero register 0, optional write-to-read bypass and a synchronous clear.
module reg_file_nrw #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 write,
    input  logic [WIDTH/8-1:0]   wstrb,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [ADDR_W-1:0]    raddr1,
    output logic [WIDTH-1:0]     rdata1,
    input  logic [ADDR_W-1:0]    raddr2,
    output logic [WIDTH-1:0]     rdata2
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned NBYTES = WIDTH / 8;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] byteMask;
    logic [WIDTH-1:0] mergedData;
    logic             wrProtected;
    logic             wrActive;

    always_comb begin
        byteMask = '0;
        for (int i = 0; i < NBYTES; i++) begin
            byteMask[8*i +: 8] = {8{wstrb[i]}};
        end
    end

    // Write data merged with the bytes the strobes leave untouched; feeds storage and bypass.
    assign mergedData  = (wdata & byteMask) | (regs[waddr] & ~byteMask);
    assign wrProtected = ZERO_REG && (waddr == '0);
    assign wrActive    = reset && write && !clear && !wrProtected;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wrActive) begin
            regs[waddr] <= mergedData;
        end
    end

    always_comb begin
        rdata1 = regs[raddr1];
        if (BYPASS && wrActive && (raddr1 == waddr)) begin
            rdata1 = mergedData;
        end
        if (!reset || (ZERO_REG && (raddr1 == '0))) begin
            rdata1 = '0;
        end
    end

    always_comb begin
        rdata2 = regs[raddr2];
        if (BYPASS && wrActive && (raddr2 == waddr)) begin
            rdata2 = mergedData;
        end
        if (!reset || (ZERO_REG && (raddr2 == '0))) begin
            rdata2 = '0;
        end
    end

endmodule

// File: tb/tb_reg_file_nrw.sv
// Bench for reg_file_nrw: two instances (zero-reg + bypass, and plain storage without bypass)
// share stimulus and are checked every cycle against a byte-level reference model.
module tb_reg_file_nrw;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned NB     = 4;

    logic              clk    = 1'b0;
    logic              reset  = 1'b0;
    logic              clear  = 1'b0;
    logic              write  = 1'b0;
    logic [NB-1:0]     wstrb  = '0;
    logic [ADDR_W-1:0] waddr  = '0;
    logic [WIDTH-1:0]  wdata  = '0;
    logic [ADDR_W-1:0] raddr1 = '0;
    logic [ADDR_W-1:0] raddr2 = '0;
    logic [WIDTH-1:0]  rdA1, rdA2, rdB1, rdB2;

    int nChecks = 0;
    int nFails  = 0;
    bit checking = 1'b0;

    // Reference storage, byte granular; index 0 = instance A, 1 = instance B.
    logic [7:0] mem [2][DEPTH][NB];

    reg_file_nrw #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(1'b1), .BYPASS(1'b1)) dutA (
        .clk(clk), .reset(reset), .clear(clear), .write(write), .wstrb(wstrb), .waddr(waddr),
        .wdata(wdata), .raddr1(raddr1), .rdata1(rdA1), .raddr2(raddr2), .rdata2(rdA2)
    );

    reg_file_nrw #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(1'b0), .BYPASS(1'b0)) dutB (
        .clk(clk), .reset(reset), .clear(clear), .write(write), .wstrb(wstrb), .waddr(waddr),
        .wdata(wdata), .raddr1(raddr1), .rdata1(rdB1), .raddr2(raddr2), .rdata2(rdB2)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset || clear) begin
            for (int k = 0; k < 2; k++)
                for (int a = 0; a < DEPTH; a++)
                    for (int b = 0; b < NB; b++)
                        mem[k][a][b] <= 8'h00;
        end else if (write) begin
            for (int k = 0; k < 2; k++)
                for (int b = 0; b < NB; b++)
                    if (wstrb[b] && !(k == 0 && waddr == '0))
                        mem[k][waddr][b] <= wdata[8*b +: 8];
        end
    end

    function automatic logic [WIDTH-1:0] expRead(input int inst, input logic [ADDR_W-1:0] ra);
        logic [WIDTH-1:0] v;
        bit zr;
        bit bp;
        zr = (inst == 0);
        bp = (inst == 0);
        if (!reset || (zr && ra == '0)) return '0;
        for (int b = 0; b < NB; b++) v[8*b +: 8] = mem[inst][ra][b];
        if (bp && write && !clear && ra == waddr)
            for (int b = 0; b < NB; b++)
                if (wstrb[b]) v[8*b +: 8] = wdata[8*b +: 8];
        return v;
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check("modelA1", rdA1, expRead(0, raddr1));
            check("modelA2", rdA2, expRead(0, raddr2));
            check("modelB1", rdB1, expRead(1, raddr1));
            check("modelB2", rdB2, expRead(1, raddr2));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drvWrite(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d,
                            input logic [NB-1:0] s);
        write = 1'b1;
        waddr = a;
        wdata = d;
        wstrb = s;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        checking = 1'b1;
        #2;
        check("resetA1", rdA1, 32'h0);
        check("resetB2", rdB2, 32'h0);

        // Asynchronous reset mid-cycle
        step();
        drvWrite(5, 32'hDEADBEEF, 4'hF);
        raddr1 = 5;
        step();
        write = 1'b0;
        #2;
        check("reg5A", rdA1, 32'hDEADBEEF);
        check("reg5B", rdB1, 32'hDEADBEEF);
        reset = 1'b0;
        #1;
        check("asyncRstA", rdA1, 32'h0);
        check("asyncRstB", rdB1, 32'h0);
        step();
        reset = 1'b1;
        #2;
        check("afterRstA", rdA1, 32'h0);

        // Byte strobes
        step();
        drvWrite(3, 32'h11223344, 4'hF);
        raddr1 = 3;
        step();
        drvWrite(3, 32'hAABBCCDD, 4'b0101);
        #2;
        check("strbBypassA", rdA1, 32'h11BB33DD);
        check("strbOldB", rdB1, 32'h11223344);
        step();
        write = 1'b0;
        #2;
        check("strbA", rdA1, 32'h11BB33DD);
        check("strbB", rdB1, 32'h11BB33DD);

        // Zero register
        step();
        drvWrite(0, 32'hFFFFFFFF, 4'hF);
        raddr1 = 0;
        raddr2 = 0;
        #2;
        check("zeroWrA1", rdA1, 32'h0);
        check("zeroWrA2", rdA2, 32'h0);
        check("zeroWrB1", rdB1, 32'h0);
        step();
        write = 1'b0;
        #2;
        check("zeroAftA1", rdA1, 32'h0);
        check("zeroAftA2", rdA2, 32'h0);
        check("reg0B", rdB1, 32'hFFFFFFFF);

        // Bypass vs no bypass
        step();
        drvWrite(7, 32'h12345678, 4'b0011);
        raddr2 = 7;
        #2;
        check("bypassA", rdA2, 32'h00005678);
        check("noBypassB", rdB2, 32'h0);
        step();
        write = 1'b0;
        #2;
        check("reg7A", rdA2, 32'h00005678);
        check("reg7B", rdB2, 32'h00005678);

        // Dual-port same address
        step();
        drvWrite(12, 32'h0BADF00D, 4'hF);
        step();
        write = 1'b0;
        raddr1 = 12;
        raddr2 = 12;
        #2;
        check("dualA1", rdA1, 32'h0BADF00D);
        check("dualA2", rdA2, 32'h0BADF00D);
        check("dualB1", rdB1, 32'h0BADF00D);
        check("dualB2", rdB2, 32'h0BADF00D);

        // Clear beats a simultaneous write
        for (int i = 1; i < DEPTH; i++) begin
            step();
            drvWrite(ADDR_W'(i), WIDTH'(i), 4'hF);
        end
        step();
        drvWrite(9, 32'hCAFE0000, 4'hF);
        clear = 1'b1;
        raddr1 = 9;
        #2;
        check("clrCycleA", rdA1, 32'h9);
        check("clrCycleB", rdB1, 32'h9);
        for (int i = 0; i < DEPTH; i++) begin
            step();
            clear = 1'b0;
            write = 1'b0;
            raddr1 = ADDR_W'(i);
            raddr2 = ADDR_W'(DEPTH - 1 - i);
            #2;
            check("clearedA", rdA1, 32'h0);
            check("clearedB", rdB2, 32'h0);
        end

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            step();
            reset  = ($urandom_range(0, 299) != 0);
            clear  = ($urandom_range(0, 63) == 0);
            write  = ($urandom_range(0, 3) != 0);
            wstrb  = NB'($urandom);
            waddr  = ADDR_W'($urandom);
            if ($urandom_range(0, 7) == 0) waddr = '0;
            wdata  = $urandom;
            raddr1 = ($urandom_range(0, 2) == 0) ? waddr : ADDR_W'($urandom);
            raddr2 = ($urandom_range(0, 2) == 0) ? waddr : ADDR_W'($urandom);
        end
        step();
        reset = 1'b1;
        write = 1'b0;
        clear = 1'b0;
        step();
        checking = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/reg_file_nrw.md
Name: reg_file_nrw

Overview:
- Parametrised multi-register storage block; the next generation of the single-bit write-enabled flip-flop.
- Provides DEPTH words of WIDTH bits, with:
  - one write port carrying per-byte write strobes;
  - two combinational read ports;
  - optional hardwired-zero register 0;
  - optional write-to-read bypass;
  - a synchronous clear.
- Serves as the CPU general-purpose register file between decode (read) and writeback (write).

Parameters:
- WIDTH, 32, bits per register; must be a multiple of 8.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is ordinary storage.
- BYPASS, 1, 1 = a read of the address being written in the same cycle returns the merged new data; 0 = the read returns the stored (old) value.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, asynchronous active-low reset; reset = 0 clears all registers immediately.
- clear, input, 1, synchronous clear of all registers at the next rising edge.
- write, input, 1, write enable.
- wstrb, input, WIDTH/8, byte write strobes; bit i enables byte i (bits 8i+7..8i).
- waddr, input, ADDR_W, write address.
- wdata, input, WIDTH, write data.
- raddr1, input, ADDR_W, read port 1 address.
- rdata1, output, WIDTH, read port 1 data (combinational).
- raddr2, input, ADDR_W, read port 2 address.
- rdata2, output, WIDTH, read port 2 data (combinational).

Behaviour:
- Reset:
  - reset falling to 0 clears every register to 0 without waiting for clk.
  - While reset = 0, writes and clear are ignored and rdata1 = rdata2 = 0.
  - Reset deassertion is not synchronised inside the block; the caller releases it away from the clk edge.
- Write:
  - At a rising clk edge with reset = 1, clear = 0 and write = 1, each byte i of register[waddr] with wstrb[i] = 1 takes wdata byte i.
  - Bytes with wstrb[i] = 0 hold their value.
  - write = 1 with wstrb = 0 changes nothing.
  - Write latency: 1 edge; the stored value is visible from the cycle after the edge.
- Clear:
  - At a rising edge with reset = 1 and clear = 1, all registers become 0.
  - clear has priority over a simultaneous write; the write is dropped.
- Zero register: with ZERO_REG = 1, writes to address 0 are discarded and reads of address 0 return 0, including under bypass.
- Read:
  - rdataN = register[raddrN], purely combinational from address and storage.
  - Both ports may read the same address simultaneously.
- Bypass:
  - Applies when BYPASS = 1, write = 1, clear = 0, reset = 1, raddrN == waddr, and the address is not zero-protected.
  - In that case rdataN = the merge of wdata (bytes with strobe = 1) and register[waddr] (bytes with strobe = 0), in the same cycle as the write.
  - If clear = 1, there is no bypass; the read shows current contents.
  - With BYPASS = 0, a same-cycle read returns the old value.
- Address range: full 2**ADDR_W decode; no out-of-range case exists.
- No X propagation: every register has a defined value after reset.

Test Plan:
- Reset: write 0xDEADBEEF to reg 5, then pulse reset = 0 between clock edges -> rdata1 (raddr1 = 5) reads 0x00000000 immediately, before any edge.
- Byte strobe:
  - write 0x11223344 to reg 3 with wstrb = 4'b1111;
  - next cycle write 0xAABBCCDD with wstrb = 4'b0101;
  - -> reg 3 reads 0x11BB33DD.
- Zero register (ZERO_REG = 1): write 0xFFFFFFFF to reg 0 -> rdata1 = rdata2 = 0 both in the write cycle and afterwards.
- Bypass (BYPASS = 1):
  - reg 7 = 0x00000000;
  - same cycle: write = 1, waddr = 7, wdata = 0x12345678, wstrb = 4'b0011, raddr2 = 7;
  - -> rdata2 = 0x00005678 in that cycle.
  - Repeat with BYPASS = 0 -> rdata2 = 0x00000000 in that cycle and 0x00005678 after the edge.
- Clear vs write: fill regs 1..31 with their index; assert clear = 1 and write = 1 (waddr = 9, wdata = 0xCAFE0000) on the same edge -> all registers read 0, including reg 9.
- Dual-port same address: raddr1 = raddr2 = 12 with reg 12 = 0x0BADF00D -> both ports return 0x0BADF00D.
